platform_hex_bank: RTL and testbench

PLATFORM_HEX_BANK -- requirements
Module: platform_hex_bank

---
 rtl/platform_hex_pkg.sv | 18 +
 rtl/platform_hex_blink_timer.sv | 42 ++++
 rtl/platform_hex_bank.sv | 107 ++++++++++
 tb/tb_platform_hex_bank.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/platform_hex_pkg.sv
// Shared constants for the hex/LED output bank.
// Register map addresses and channel limits.
package platform_hex_pkg;

  localparam int MAX_NCHAN = 8;
  localparam int AW        = 5;

  localparam logic [AW-1:0] ADDR_BLINK_MASK = 5'h10;
  localparam logic [AW-1:0] ADDR_STATUS     = 5'h11;

  function automatic logic is_data_addr(
    input logic [AW-1:0] a,
    input int            nchan
  );
    return 32'(a) < 32'(nchan);
  endfunction

endpackage

// File: rtl/platform_hex_blink_timer.sv
// Blink prescaler and phase flip-flop.
// clear restarts the count and forces the visible phase.
module platform_hex_blink_timer #(
  parameter int unsigned DIV = 25000000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  output logic phase,
  output logic wrap
);

  logic [31:0] cnt_q, cnt_d;
  logic        phase_q, phase_d;

  assign wrap  = (cnt_q == 32'(DIV - 1));
  assign phase = phase_q;

  // clear dominates a coincident wrap
  always_comb begin
    cnt_d   = cnt_q + 32'd1;
    phase_d = phase_q;
    if (clear) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (wrap) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/platform_hex_bank.sv
// Memory-mapped bank of NCHAN output channels with optional
// blanking blink (PLATFORM_HEX_BANK_BLINK_EN).
module platform_hex_bank
  import platform_hex_pkg::*;
#(
  parameter int          NCHAN     = 6,
  parameter int          DW        = 8,
  parameter int unsigned BLINK_DIV = 25000000,
  parameter logic [DW-1:0] OFF_VAL = {DW{1'b1}}
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [4:0]          address,
  input  logic                chipselect,
  input  logic                write_n,
  input  logic [31:0]         writedata,
  output logic [31:0]         readdata,
  output logic [NCHAN*DW-1:0] out_port
);

  if (NCHAN < 1 || NCHAN > MAX_NCHAN) begin : g_bad_nchan
    $error("NCHAN out of range");
  end
  if (DW < 1 || DW > 32) begin : g_bad_dw
    $error("DW out of range");
  end
  if (BLINK_DIV < 2) begin : g_bad_div
    $error("BLINK_DIV out of range");
  end

  logic              wr_en;
  logic [DW-1:0]     data_q [NCHAN];
  logic [NCHAN*DW-1:0] out_q;
  logic [NCHAN-1:0]  mask;
  logic              phase;
  logic              unused_wd;

  assign wr_en     = chipselect & ~write_n;
  assign unused_wd = ^writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NCHAN; i++)
        data_q[i] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NCHAN; i++)
        if (address == 5'(i))
          data_q[i] <= writedata[DW-1:0];
    end
  end

`ifdef PLATFORM_HEX_BANK_BLINK_EN
  logic [NCHAN-1:0] mask_q;
  logic             mask_wr;
  logic             unused_wrap;

  assign mask_wr = wr_en && (address == ADDR_BLINK_MASK);
  assign mask    = mask_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      mask_q <= '0;
    else if (mask_wr)
      mask_q <= writedata[NCHAN-1:0];
  end

  platform_hex_blink_timer #(
    .DIV (BLINK_DIV)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (mask_wr),
    .phase   (phase),
    .wrap    (unused_wrap)
  );
`else
  assign mask  = '0;
  assign phase = 1'b0;
`endif

  always_comb begin
    readdata = '0;
    for (int i = 0; i < NCHAN; i++)
      if (address == 5'(i))
        readdata = 32'(data_q[i]);
`ifdef PLATFORM_HEX_BANK_BLINK_EN
    unique case (1'b1)
      (address == ADDR_BLINK_MASK): readdata = 32'(mask);
      (address == ADDR_STATUS):     readdata = {31'b0, phase};
      default: ;
    endcase
`endif
  end

  // output lags register state by one cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q <= '0;
    end else begin
      for (int i = 0; i < NCHAN; i++)
        out_q[i*DW +: DW] <= (mask[i] & phase) ? OFF_VAL : data_q[i];
    end
  end

  assign out_port = out_q;

endmodule

// File: tb/tb_platform_hex_bank.sv
// Directed self-checking bench for platform_hex_bank.
// NCHAN=6, DW=8, BLINK_DIV=4.
module tb_platform_hex_bank;

  logic        clk;
  logic        reset_n;
  logic [4:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [47:0] out_port;

  int errs;
  int checks;

  platform_hex_bank #(
    .NCHAN     (6),
    .DW        (8),
    .BLINK_DIV (4)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] v);
    address = a;
    #1;
    v = readdata;
  endtask

  function automatic logic [7:0] ch(input logic [47:0] o, input int i);
    return o[i*8 +: 8];
  endfunction

  task automatic test_reset;
    logic [31:0] v;
    #1;
    checks++;
    if (out_port !== 48'h0) begin
      errs++;
      $display("FAIL reset_out: got %h want 0", out_port);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int a = 0; a < 32; a++) begin
      rd(5'(a), v);
      checks++;
      if (v !== 32'h0) begin
        errs++;
        $display("FAIL reset_rd[%0d]: got %h want 0", a, v);
      end
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_port !== 48'h0) begin
      errs++;
      $display("FAIL reset_out2: got %h want 0", out_port);
    end
  endtask

  task automatic test_data_write;
    logic [31:0] v;
    wr(5'd2, 32'h1234_5679);
    checks++;
    if (out_port !== 48'h0) begin
      errs++;
      $display("FAIL dw_early: got %h want 0", out_port);
    end
    rd(5'd2, v);
    checks++;
    if (v !== 32'h79) begin
      errs++;
      $display("FAIL dw_rd: got %h want 79", v);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_port !== 48'h0000_0079_0000) begin
      errs++;
      $display("FAIL dw_out: got %h want 000000790000", out_port);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] v;
    logic [7:0]  vals [6];
    vals = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    for (int i = 0; i < 6; i++)
      wr(5'(i), {24'hABCDEF, vals[i]});
    @(posedge clk);
    #1;
    checks++;
    if (out_port !== 48'h6655_4433_2211) begin
      errs++;
      $display("FAIL b2b_out: got %h want 665544332211", out_port);
    end
    for (int i = 0; i < 6; i++) begin
      rd(5'(i), v);
      checks++;
      if (v !== {24'h0, vals[i]}) begin
        errs++;
        $display("FAIL b2b_rd[%0d]: got %h want %h", i, v, vals[i]);
      end
    end
  endtask

  task automatic test_strobes;
    logic [31:0] v;
    @(negedge clk);
    address    = 5'd0;
    writedata  = 32'hAA;
    chipselect = 1'b0;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b1;
    write_n    = 1'b1;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    rd(5'd0, v);
    checks++;
    if (v !== 32'h11) begin
      errs++;
      $display("FAIL strobe_rd: got %h want 11", v);
    end
  endtask

  task automatic test_unmapped;
    logic [31:0] v;
    wr(5'd7, 32'hFF);
    wr(5'h11, 32'hFF);
    wr(5'h1F, 32'hFF);
    rd(5'd7, v);
    checks++;
    if (v !== 32'h0) begin
      errs++;
      $display("FAIL unm_rd7: got %h want 0", v);
    end
    rd(5'h11, v);
    checks++;
    if (v !== 32'h0) begin
      errs++;
      $display("FAIL unm_rd11: got %h want 0", v);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_port !== 48'h6655_4433_2211) begin
      errs++;
      $display("FAIL unm_out: got %h want 665544332211", out_port);
    end
  endtask

`ifdef PLATFORM_HEX_BANK_BLINK_EN
  task automatic test_blink;
    logic [31:0] v;
    logic [7:0]  e0;
    wr(5'd0, 32'h3F);
    wr(5'd1, 32'h55);
    wr(5'h10, 32'h01);
    rd(5'h10, v);
    checks++;
    if (v !== 32'h1) begin
      errs++;
      $display("FAIL blink_mask_rd: got %h want 1", v);
    end
    for (int j = 0; j <= 16; j++) begin
      e0 = (j == 0 || ((j - 1) / 4) % 2 == 0) ? 8'h3F : 8'hFF;
      checks++;
      if (ch(out_port, 0) !== e0) begin
        errs++;
        $display("FAIL blink_ch0 j=%0d: got %h want %h",
                 j, ch(out_port, 0), e0);
      end
      checks++;
      if (ch(out_port, 1) !== 8'h55) begin
        errs++;
        $display("FAIL blink_ch1 j=%0d: got %h want 55",
                 j, ch(out_port, 1));
      end
      rd(5'h11, v);
      checks++;
      if (v !== 32'((j / 4) % 2)) begin
        errs++;
        $display("FAIL blink_status j=%0d: got %h want %0d",
                 j, v, (j / 4) % 2);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_mask_on_wrap;
    logic [31:0] v;
    wr(5'h10, 32'h01);
    repeat (3) @(posedge clk);
    wr(5'h10, 32'h01);
    rd(5'h11, v);
    checks++;
    if (v !== 32'h0) begin
      errs++;
      $display("FAIL wrap_clear: got %h want 0", v);
    end
    for (int j = 1; j <= 4; j++) begin
      @(posedge clk);
      #1;
      rd(5'h11, v);
      checks++;
      if (v !== ((j == 4) ? 32'h1 : 32'h0)) begin
        errs++;
        $display("FAIL wrap_next j=%0d: got %h want %0d",
                 j, v, (j == 4));
      end
    end
  endtask

  task automatic test_reset_mid_blink;
    logic [31:0] v;
    wr(5'h10, 32'h01);
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (ch(out_port, 0) !== 8'hFF) begin
      errs++;
      $display("FAIL mid_pre: got %h want ff", ch(out_port, 0));
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (out_port !== 48'h0) begin
      errs++;
      $display("FAIL mid_async: got %h want 0", out_port);
    end
    rd(5'h11, v);
    checks++;
    if (v !== 32'h0) begin
      errs++;
      $display("FAIL mid_status: got %h want 0", v);
    end
    rd(5'd0, v);
    checks++;
    if (v !== 32'h0) begin
      errs++;
      $display("FAIL mid_data: got %h want 0", v);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int j = 0; j <= 4; j++) begin
      @(posedge clk);
      #1;
      rd(5'h11, v);
      if (j < 3 || j == 4) begin
        checks++;
        if (v !== ((j == 4) ? 32'h1 : 32'h0)) begin
          errs++;
          $display("FAIL mid_resume j=%0d: got %h want %0d",
                   j, v, (j == 4));
        end
      end
    end
  endtask
`else
  task automatic test_no_blink;
    logic [31:0] v;
    wr(5'h10, 32'hFF);
    wr(5'h11, 32'h01);
    rd(5'h10, v);
    checks++;
    if (v !== 32'h0) begin
      errs++;
      $display("FAIL nob_rd10: got %h want 0", v);
    end
    rd(5'h11, v);
    checks++;
    if (v !== 32'h0) begin
      errs++;
      $display("FAIL nob_rd11: got %h want 0", v);
    end
    repeat (6) begin
      @(posedge clk);
      #1;
      checks++;
      if (out_port !== 48'h6655_4433_2211) begin
        errs++;
        $display("FAIL nob_out: got %h want 665544332211", out_port);
      end
    end
    wr(5'd5, 32'hC3);
    checks++;
    if (ch(out_port, 5) !== 8'h66) begin
      errs++;
      $display("FAIL nob_lat0: got %h want 66", ch(out_port, 5));
    end
    @(posedge clk);
    #1;
    checks++;
    if (ch(out_port, 5) !== 8'hC3) begin
      errs++;
      $display("FAIL nob_lat1: got %h want c3", ch(out_port, 5));
    end
  endtask
`endif

  initial begin
    errs       = 0;
    checks     = 0;
    reset_n    = 1'b0;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    repeat (3) @(posedge clk);
    test_reset;
    test_data_write;
    test_back_to_back;
    test_strobes;
    test_unmapped;
`ifdef PLATFORM_HEX_BANK_BLINK_EN
    test_blink;
    test_mask_on_wrap;
    test_reset_mid_blink;
`else
    test_no_blink;
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
